// File: rtl/branch_unit_if.sv
// Branch unit bus: ID instruction handshake, condition evaluator link,
// redirect handshake to fetch, link write, error pulse and perf counters.
// master = pipeline side driving ID/evaluator/fetch; slave = branch_unit.
interface branch_unit_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      id_instr;
    logic [31:0]      id_pc;
    logic [3:0]       bf;
    logic             bcres;
    logic [31:0]      rs_val;
    logic             redir_valid;
    logic             redir_ready;
    logic [31:0]      redir_target;
    logic             flush;
    logic             link_we;
    logic [31:0]      link_data;
    logic             addr_err;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] tkn_cnt;

    modport master (
        output id_valid, id_instr, id_pc, bcres, rs_val, redir_ready,
        input  id_ready, bf, redir_valid, redir_target, flush,
        input  link_we, link_data, addr_err, br_cnt, tkn_cnt
    );

    modport slave (
        input  id_valid, id_instr, id_pc, bcres, rs_val, redir_ready,
        output id_ready, bf, redir_valid, redir_target, flush,
        output link_we, link_data, addr_err, br_cnt, tkn_cnt
    );
endinterface

// File: rtl/branch_unit.sv
// Branch/jump resolution: decodes ID branches into a bf code, resolves in EX
// with the evaluator's bcres, and issues a buffered redirect + flush to fetch.
// Ports: clk, reset (async, active-high), bus (branch_unit_if.slave).
module branch_unit #(
    parameter int          CNT_W       = 32,
    parameter logic [31:0] LINK_OFFSET = 32'd4
) (
    input  logic          clk,
    input  logic          reset,
    branch_unit_if.slave  bus
);
    typedef enum logic [2:0] {
        K_NONE,
        K_COND,
        K_J,
        K_JAL,
        K_JR
    } kind_t;

    logic [5:0]  op;
    logic [4:0]  rt;
    logic [5:0]  fn;
    logic [31:0] pc4;
    logic [31:0] br_off;
    kind_t       dec_kind;
    logic [3:0]  dec_bf;
    logic [31:0] dec_target;

    logic        ex_valid;
    kind_t       ex_kind;
    logic [3:0]  ex_bf;
    logic [31:0] ex_target;
    logic [31:0] ex_pc;

    logic        redir_q;
    logic [31:0] redir_tgt_q;
    logic        flush_q;
    logic [CNT_W-1:0] br_q;
    logic [CNT_W-1:0] tkn_q;

    logic        resolving;
    logic        jr_bad;
    logic        uncond;
    logic        taken;
    logic [31:0] res_target;
    logic        ready;
    logic        accept;

    assign op     = bus.id_instr[31:26];
    assign rt     = bus.id_instr[20:16];
    assign fn     = bus.id_instr[5:0];
    assign pc4    = bus.id_pc + 32'd4;
    assign br_off = {{14{bus.id_instr[15]}}, bus.id_instr[15:0], 2'b00};

    always_comb begin
        dec_kind = K_NONE;
        dec_bf   = 4'b0000;
        case (op)
            6'd0: if (fn == 6'd8) dec_kind = K_JR;
            6'd1: begin
                if (rt == 5'd0) begin
                    dec_kind = K_COND;
                    dec_bf   = 4'b0010;
                end else if (rt == 5'd1) begin
                    dec_kind = K_COND;
                    dec_bf   = 4'b0011;
                end
            end
            6'd2: dec_kind = K_J;
            6'd3: dec_kind = K_JAL;
            6'd4: begin dec_kind = K_COND; dec_bf = 4'b1000; end
            6'd5: begin dec_kind = K_COND; dec_bf = 4'b1010; end
            6'd6: begin dec_kind = K_COND; dec_bf = 4'b1100; end
            6'd7: begin dec_kind = K_COND; dec_bf = 4'b1110; end
            default: ;
        endcase
    end

    // JR target comes from the forwarded rs value in EX, not from decode.
    always_comb begin
        dec_target = 32'd0;
        if (dec_kind == K_COND)
            dec_target = pc4 + br_off;
        else if (dec_kind == K_J || dec_kind == K_JAL)
            dec_target = {pc4[31:28], bus.id_instr[25:0], 2'b00};
    end

    assign resolving  = ex_valid && (ex_kind != K_NONE);
    assign jr_bad     = (ex_kind == K_JR) && (bus.rs_val[1:0] != 2'b00);
    assign uncond     = (ex_kind == K_J) || (ex_kind == K_JAL) ||
                        (ex_kind == K_JR);
    assign taken      = resolving && !jr_bad &&
                        (uncond || ((ex_kind == K_COND) && bus.bcres));
    assign res_target = (ex_kind == K_JR) ? bus.rs_val : ex_target;

    // The instruction refused during a taken resolve is younger and gets
    // killed by the flush, so it is simply never captured.
    assign ready  = !reset && !redir_q && !taken;
    assign accept = bus.id_valid && ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_kind   <= K_NONE;
            ex_bf     <= 4'b0000;
            ex_target <= 32'd0;
            ex_pc     <= 32'd0;
        end else begin
            ex_valid <= accept;
            if (accept) begin
                ex_kind   <= dec_kind;
                ex_bf     <= dec_bf;
                ex_target <= dec_target;
                ex_pc     <= bus.id_pc;
            end
        end
    end

    // No new redirect can arise while one is pending: id_ready is low, so
    // EX is empty for as long as redir_q is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redir_q     <= 1'b0;
            redir_tgt_q <= 32'd0;
            flush_q     <= 1'b0;
        end else begin
            flush_q <= taken;
            if (taken) begin
                redir_q     <= 1'b1;
                redir_tgt_q <= res_target;
            end else if (redir_q && bus.redir_ready) begin
                redir_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_q  <= '0;
            tkn_q <= '0;
        end else begin
            if (resolving)
                br_q <= br_q + CNT_W'(1);
            if (taken)
                tkn_q <= tkn_q + CNT_W'(1);
        end
    end

    assign bus.id_ready     = ready;
    assign bus.bf           = ex_valid ? ex_bf : 4'b0000;
    assign bus.redir_valid  = redir_q;
    assign bus.redir_target = redir_tgt_q;
    assign bus.flush        = flush_q;
    assign bus.link_we      = resolving && (ex_kind == K_JAL);
    assign bus.link_data    = bus.link_we ? (ex_pc + LINK_OFFSET) : 32'd0;
    assign bus.addr_err     = resolving && jr_bad;
    assign bus.br_cnt       = br_q;
    assign bus.tkn_cnt      = tkn_q;
endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed branch/jump sequences with a
// queue of expected redirect targets checked on each redirect handshake.
module tb_branch_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_q[$];
    int   exp_br;
    int   exp_tkn;

    branch_unit_if #(.CNT_W(32)) bif ();

    branch_unit #(.CNT_W(32), .LINK_OFFSET(32'd4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.id_valid = 1'b0;
        bif.id_instr = 32'd0;
        bif.id_pc    = 32'd0;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        bif.id_valid = 1'b1;
        bif.id_instr = instr;
        bif.id_pc    = pc;
    endtask

    task automatic cnts(input string tag);
        check({tag, "_br"}, 64'(bif.br_cnt), 64'(exp_br));
        check({tag, "_tkn"}, 64'(bif.tkn_cnt), 64'(exp_tkn));
    endtask

    always @(negedge clk) begin
        if (!reset && bif.redir_valid && bif.redir_ready) begin
            if (exp_q.size() == 0)
                check("redir_unexp", 64'(bif.redir_target), 64'hffff_ffff_0000_0000);
            else
                check("redir_tgt", 64'(bif.redir_target), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] I_BEQ  = 32'h1000_0004;
    localparam logic [31:0] I_BGEZ = 32'h0401_0008;
    localparam logic [31:0] I_ADD  = 32'h0109_5020;
    localparam logic [31:0] I_JAL  = 32'h0C10_0000;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_BNEG = 32'h1000_FFFF;
    localparam logic [31:0] I_BNE  = 32'h1400_0002;

    logic [31:0] tbl_instr [6];
    logic [3:0]  tbl_bf    [6];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_br   = 0;
        exp_tkn  = 0;
        reset    = 1'b1;
        idle();
        bif.bcres       = 1'b0;
        bif.rs_val      = 32'd0;
        bif.redir_ready = 1'b1;
        tbl_instr = '{32'h0400_0001, 32'h0401_0001, 32'h1000_0001,
                      32'h1400_0001, 32'h1800_0001, 32'h1C00_0001};
        tbl_bf    = '{4'b0010, 4'b0011, 4'b1000, 4'b1010, 4'b1100, 4'b1110};

        #2;
        check("rst_ready", 64'(bif.id_ready), 0);
        check("rst_redir", 64'(bif.redir_valid), 0);
        check("rst_bf", 64'(bif.bf), 0);
        cnts("rst");
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(bif.id_ready), 1);

        // BEQ taken: target 0x104 + 0x10
        tick();
        drive(I_BEQ, 32'h100);
        exp_q.push_back(32'h114);
        tick();
        idle();
        bif.bcres = 1'b1;
        #1;
        check("beq_bf", 64'(bif.bf), 64'(4'b1000));
        check("beq_ready_res", 64'(bif.id_ready), 0);
        tick();
        bif.bcres = 1'b0;
        exp_br++;
        exp_tkn++;
        #1;
        check("beq_redir", 64'(bif.redir_valid), 1);
        check("beq_tgt", 64'(bif.redir_target), 64'h114);
        check("beq_flush", 64'(bif.flush), 1);
        cnts("beq");
        tick();
        #1;
        check("beq_flush_end", 64'(bif.flush), 0);
        check("beq_redir_end", 64'(bif.redir_valid), 0);
        check("beq_ready_end", 64'(bif.id_ready), 1);

        // BGEZ not taken, ADD right behind it
        drive(I_BGEZ, 32'h200);
        tick();
        drive(I_ADD, 32'h204);
        bif.bcres = 1'b0;
        #1;
        check("bgez_bf", 64'(bif.bf), 64'(4'b0011));
        check("bgez_ready", 64'(bif.id_ready), 1);
        tick();
        idle();
        exp_br++;
        #1;
        check("add_bf", 64'(bif.bf), 0);
        check("bgez_redir", 64'(bif.redir_valid), 0);
        check("bgez_flush", 64'(bif.flush), 0);
        tick();
        #1;
        cnts("bgez");

        // JAL: link write and region jump
        drive(I_JAL, 32'h0040_0010);
        exp_q.push_back(32'h0040_0000);
        tick();
        idle();
        #1;
        check("jal_link_we", 64'(bif.link_we), 1);
        check("jal_link_data", 64'(bif.link_data), 64'h0040_0014);
        check("jal_bf", 64'(bif.bf), 0);
        tick();
        exp_br++;
        exp_tkn++;
        #1;
        check("jal_link_we_end", 64'(bif.link_we), 0);
        check("jal_tgt", 64'(bif.redir_target), 64'h0040_0000);
        cnts("jal");
        tick();

        // JR misaligned
        drive(I_JR, 32'h300);
        tick();
        idle();
        bif.rs_val = 32'h1002;
        #1;
        check("jr_addr_err", 64'(bif.addr_err), 1);
        check("jr_bad_ready", 64'(bif.id_ready), 1);
        tick();
        exp_br++;
        #1;
        check("jr_addr_err_end", 64'(bif.addr_err), 0);
        check("jr_bad_redir", 64'(bif.redir_valid), 0);
        cnts("jr_bad");

        // JR aligned with fetch stalling for 3 cycles
        drive(I_JR, 32'h304);
        bif.redir_ready = 1'b0;
        tick();
        idle();
        bif.rs_val = 32'h1000;
        exp_q.push_back(32'h1000);
        #1;
        check("jr_ready_res", 64'(bif.id_ready), 0);
        tick();
        exp_br++;
        exp_tkn++;
        bif.rs_val = 32'hdead_beec;
        drive(I_BEQ, 32'h400);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("jr_hold_valid", 64'(bif.redir_valid), 1);
            check("jr_hold_tgt", 64'(bif.redir_target), 64'h1000);
            check("jr_hold_ready", 64'(bif.id_ready), 0);
            if (i == 2)
                bif.redir_ready = 1'b1;
            tick();
        end
        idle();
        #1;
        check("jr_clear", 64'(bif.redir_valid), 0);
        check("jr_not_captured", 64'(bif.bf), 0);
        check("jr_ready_end", 64'(bif.id_ready), 1);
        cnts("jr");

        // Younger instruction during a taken resolve (negative offset)
        drive(I_BNEG, 32'h500);
        exp_q.push_back(32'h500);
        tick();
        drive(I_BNE, 32'h504);
        bif.bcres = 1'b1;
        #1;
        check("young_ready", 64'(bif.id_ready), 0);
        tick();
        idle();
        bif.bcres = 1'b0;
        exp_br++;
        exp_tkn++;
        #1;
        check("young_bf", 64'(bif.bf), 0);
        check("young_flush", 64'(bif.flush), 1);
        cnts("young");
        tick();

        // All conditional encodings, back to back, not taken
        for (int i = 0; i < 6; i++) begin
            drive(tbl_instr[i], 32'h800 + 32'(i * 4));
            if (i > 0) begin
                #1;
                check("tbl_bf", 64'(bif.bf), 64'(tbl_bf[i-1]));
                exp_br++;
            end
            tick();
        end
        idle();
        #1;
        check("tbl_bf_last", 64'(bif.bf), 64'(tbl_bf[5]));
        tick();
        exp_br++;
        #1;
        cnts("tbl");

        // BNE taken, redirect pending, async reset mid-cycle
        drive(I_BNE, 32'h600);
        bif.redir_ready = 1'b0;
        tick();
        idle();
        bif.bcres = 1'b1;
        tick();
        bif.bcres = 1'b0;
        #1;
        check("bne_pend", 64'(bif.redir_valid), 1);
        check("bne_tgt", 64'(bif.redir_target), 64'h60C);
        #1;
        reset = 1'b1;
        exp_br = 0;
        exp_tkn = 0;
        #1;
        check("arst_redir", 64'(bif.redir_valid), 0);
        check("arst_tgt", 64'(bif.redir_target), 0);
        check("arst_flush", 64'(bif.flush), 0);
        check("arst_ready", 64'(bif.id_ready), 0);
        cnts("arst");
        tick();
        reset = 1'b0;
        bif.redir_ready = 1'b1;
        #1;
        check("arst_ready_end", 64'(bif.id_ready), 1);
        tick();

        check("sb_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
